mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Word-organised data/instruction memory that answers the multicycle CPU control unit's memory accesses.
- Sits on the CPU memory port. It takes the byte address selected by IorD, the B-register write data and the memWriteOrRead strobe, and returns read data after a fixed latency that matches the control unit's fetch and load timing (MemoryRead → WaitMemoryRead → IRWrite).
- Also provides a testbench/boot preload port, an alignment error flag and access counters.

Parameters:
- DEPTH, 256, number of 32-bit words stored; power of two, 16..4096.
- LATENCY, 2, clock edges from address sample to rdata update; legal 1..4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- addr  in  32  byte address from CPU.
- wdata  in  32  write data from CPU.
- wr  in  1  1 = write, 0 = read (CPU memWriteOrRead).
- init_we  in  1  preload write enable.
- init_addr  in  $clog2(DEPTH)  preload word index.
- init_data  in  32  preload word.
- rdata  out  32  read data to CPU (IR/MDR).
- rvalid  out  1  one-cycle pulse when rdata updated.
- busy  out  1  any read in flight in the delay line.
- err  out  1  sticky misaligned-access flag.
- rd_count  out  16  completed reads, saturating.
- wr_count  out  16  committed writes, saturating.

Behaviour:
- Reset (async, any time, including mid-read):
  - rdata=0, rvalid=0, busy=0, err=0, rd_count=0, wr_count=0.
  - All delay-line valid bits cleared; in-flight reads are discarded and never produce rvalid.
  - Memory array contents are NOT cleared.
- Word index = addr[$clog2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4 with no error.
- Read issue: every rising edge with wr=0 and reset low pushes {index, valid=1} into stage 0 of the delay line. A wr=1 edge pushes valid=0. No request strobe exists; the CPU holds addr stable.
- Delay line: LATENCY stages, advances every edge, never stalls.
- Read completion: on the edge where stage LATENCY-1 is valid:
  - rdata <= array[stage index];
  - rvalid=1 for the following cycle;
  - rd_count += 1, saturating at 16'hFFFF.
  - With no valid completion, rdata holds its value and rvalid=0.
- With LATENCY=2: addr presented in cycle n, rdata valid from cycle n+2. Repeated reads of a held address in cycles n, n+1, n+2 update rdata each cycle with the same word.
- Write: on an edge with wr=1 and addr[1:0]==0, array[index] <= wdata and wr_count += 1 (saturating). The CPU holding wr for two cycles (SW_step2, SW_step3_wait) is two commits of the same value and counts 2.
- Misaligned access (addr[1:0]!=0):
  - write: suppressed, err <= 1;
  - read: returns the aligned-down word, err <= 1.
  - err clears only on reset.
- Write/read collision: a write and a read completion to the same index on the same edge → rdata gets wdata (write-first).
- Preload collision: init_we=1 has priority over wr. On an edge with both:
  - init_data is written to array[init_addr];
  - the CPU write is dropped and wr_count is not incremented;
  - preload writes never touch the counters.
  - A read completion to init_addr on the same edge returns init_data.
- busy = OR of delay-line valid bits (combinational).

Decomposition:
- Package mem_pkg:
  - WORD_W=32;
  - typedef word_t (logic [31:0]);
  - constants MEM_READ=1'b0 and MEM_WRITE=1'b1, matching the control unit's memWriteOrRead encoding;
  - COUNT_MAX=16'hFFFF.
- Sub-module mem_delay_line, parameterised by LATENCY and index width:
  - shift register of {valid, index} with async reset of the valid bits;
  - outputs the final stage and the busy OR.
- mem_responder holds the array, the write/preload arbitration, the forwarding mux, and the err flag and counters.

Test Plan:
- Fetch timing: preload word 3 = 0x8C220004; addr=0x0C, wr=0 at cycle 0 → rdata=0x8C220004 and rvalid=1 in cycle 2 (LATENCY=2); busy=1 in cycles 1-2; rd_count ≥1.
- Store then load: wr=1, addr=0x40, wdata=0xDEADBEEF for 2 cycles → wr_count=2; then read 0x40 → rdata=0xDEADBEEF two cycles later.
- Collision: read 0x20 issued at cycle 0, write 0x20=0x12345678 at the edge ending cycle 1 → rdata=0x12345678 at cycle 2. Repeat with init_we to index 8 and a same-edge CPU write → array holds init_data, wr_count unchanged.
- Misalignment and wrap:
  - write addr=0x42 → array unchanged, err=1;
  - read addr=0x401 with DEPTH=256 → returns word 0, err stays 1.
- Reset mid-read: issue read at cycle 0, assert reset in cycle 1 → rvalid never pulses; rdata=0, counters=0, err=0; preloaded contents intact on a subsequent read.
- Saturation: preload rd_count path by 65 540 consecutive reads → rd_count=16'hFFFF and holds.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_pkg                                                            |
// | Shared types and constants for the CPU memory responder.           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mem_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Matches the control unit's memWriteOrRead encoding
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  function automatic logic [15:0] satInc(input logic [15:0] value);
    return (value == COUNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_delay_line                                                     |
// | Non-stalling read pipeline of {valid, index} entries.              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_delay_line #(
  parameter int LATENCY = 2,
  parameter int IDX_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  input  logic [IDX_W-1:0] inIdx,
  output logic             doneValid,
  output logic [IDX_W-1:0] doneIdx,
  output logic             lastValid,
  output logic             busy
);

  logic [LATENCY-1:0] r_valid;

  // The read completes on the edge that loads the final stage, so the
  // final stage only needs its valid bit (it becomes the rvalid pulse).
  generate
    if (LATENCY == 1) begin : g_single
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_valid <= '0;
        else       r_valid <= inValid;
      end

      assign doneValid = inValid;
      assign doneIdx   = inIdx;
    end else begin : g_multi
      logic [IDX_W-1:0] r_idx [LATENCY-1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_valid <= '0;
        else       r_valid <= {r_valid[LATENCY-2:0], inValid};
      end

      always_ff @(posedge clk) begin
        r_idx[0] <= inIdx;
        for (int i = 1; i < LATENCY - 1; i++) begin
          r_idx[i] <= r_idx[i-1];
        end
      end

      assign doneValid = r_valid[LATENCY-2];
      assign doneIdx   = r_idx[LATENCY-2];
    end
  endgenerate

  assign lastValid = r_valid[LATENCY-1];
  assign busy      = |r_valid;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_responder                                                      |
// | Word memory with fixed-latency reads, preload port and counters.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  input  logic                     wr,
  input  logic                     init_we,
  input  logic [$clog2(DEPTH)-1:0] init_addr,
  input  logic [31:0]              init_data,
  output logic [31:0]              rdata,
  output logic                     rvalid,
  output logic                     busy,
  output logic                     err,
  output logic [15:0]              rd_count,
  output logic [15:0]              wr_count
);

  localparam int IDX_W = $clog2(DEPTH);

  word_t            r_mem [DEPTH];
  word_t            r_rdata;
  logic             r_err;
  logic [15:0]      r_rdCount;
  logic [15:0]      r_wrCount;

  logic [IDX_W-1:0] w_idx;
  logic             w_aligned;
  logic             w_cpuWrite;
  logic             w_doneValid;
  logic [IDX_W-1:0] w_doneIdx;
  logic             w_lastValid;
  word_t            w_fwdData;
  logic             w_unusedAddrHi;

  // Upper address bits wrap silently
  assign w_idx          = addr[IDX_W+1:2];
  assign w_unusedAddrHi = ^addr[WORD_W-1:IDX_W+2];
  assign w_aligned      = (addr[1:0] == 2'b00);
  assign w_cpuWrite     = (wr == MEM_WRITE) && w_aligned && !init_we;

  mem_delay_line #(
    .LATENCY (LATENCY),
    .IDX_W   (IDX_W)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .inValid   (wr == MEM_READ),
    .inIdx     (w_idx),
    .doneValid (w_doneValid),
    .doneIdx   (w_doneIdx),
    .lastValid (w_lastValid),
    .busy      (busy)
  );

  always_ff @(posedge clk) begin
    if (init_we) begin
      r_mem[init_addr] <= init_data;
    end else if (w_cpuWrite) begin
      r_mem[w_idx] <= wdata;
    end
  end

  // Same-edge writes are forwarded so a completing read sees the new word
  always_comb begin
    w_fwdData = r_mem[w_doneIdx];
    if (init_we) begin
      if (init_addr == w_doneIdx) w_fwdData = init_data;
    end else if (w_cpuWrite && (w_idx == w_doneIdx)) begin
      w_fwdData = wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_rdCount <= '0;
      r_wrCount <= '0;
    end else begin
      if (w_doneValid) begin
        r_rdata   <= w_fwdData;
        r_rdCount <= satInc(r_rdCount);
      end
      if (w_cpuWrite) begin
        r_wrCount <= satInc(r_wrCount);
      end
      if (!w_aligned) begin
        r_err <= 1'b1;
      end
    end
  end

  assign rdata    = r_rdata;
  assign rvalid   = w_lastValid;
  assign err      = r_err;
  assign rd_count = r_rdCount;
  assign wr_count = r_wrCount;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// Randomised and directed bench for mem_responder against a queue-based
// model of in-flight reads.
module tb_mem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        init_we;
  logic [7:0]  init_addr;
  logic [31:0] init_data;
  logic [31:0] rdata;
  logic        rvalid;
  logic        busy;
  logic        err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .wr        (wr),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .busy      (busy),
    .err       (err),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A read lives LATENCY edges counting its issue edge; it returns data on
  // the last of them and is reported by rvalid in the cycle after.
  typedef struct {
    int idx;
    int age;
  } rd_t;

  rd_t         q[$];
  logic [31:0] mMem [DEPTH];
  logic [31:0] mRdata;
  logic        mRvalid;
  logic        mErr;
  logic [15:0] mRd;
  logic [15:0] mWr;

  int checks = 0;
  int errors = 0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    mRdata  = '0;
    mRvalid = 1'b0;
    mErr    = 1'b0;
    mRd     = '0;
    mWr     = '0;
  endtask

  task automatic modelEdge(input logic [31:0] a, input logic [31:0] d, input logic w,
                           input logic iw, input logic [7:0] ia, input logic [31:0] id);
    int  idx     = int'((a >> 2) % DEPTH);
    bit  aligned = (a[1:0] == 2'b00);
    rd_t keep[$];
    foreach (q[i]) q[i].age++;
    if (!w) q.push_back('{idx: idx, age: 0});
    mRvalid = 1'b0;
    foreach (q[i]) begin
      if (q[i].age == LATENCY - 1) begin
        mRvalid = 1'b1;
        if (iw && int'(ia) == q[i].idx)                 mRdata = id;
        else if (!iw && w && aligned && idx == q[i].idx) mRdata = d;
        else                                             mRdata = mMem[q[i].idx];
        if (mRd != 16'hFFFF) mRd++;
      end
    end
    foreach (q[i]) if (q[i].age < LATENCY) keep.push_back(q[i]);
    q = keep;
    if (!aligned) mErr = 1'b1;
    if (iw) begin
      mMem[ia] = id;
    end else if (w && aligned) begin
      mMem[idx] = d;
      if (mWr != 16'hFFFF) mWr++;
    end
  endtask

  task automatic compareAll();
    checkEq("rdata", rdata, mRdata);
    checkEq("rvalid", {31'b0, rvalid}, {31'b0, mRvalid});
    checkEq("busy", {31'b0, busy}, {31'b0, q.size() != 0});
    checkEq("err", {31'b0, err}, {31'b0, mErr});
    checkEq("rd_count", {16'b0, rd_count}, {16'b0, mRd});
    checkEq("wr_count", {16'b0, wr_count}, {16'b0, mWr});
  endtask

  // Called at a falling edge: drive, take one rising edge, check at the next fall
  task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic iw, input logic [7:0] ia, input logic [31:0] id);
    addr = a; wdata = d; wr = w; init_we = iw; init_addr = ia; init_data = id;
    @(posedge clk);
    modelEdge(a, d, w, iw, ia, id);
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; wr = 1'b1;
    init_we = 1'b0; init_addr = '0; init_data = '0;
    modelReset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    compareAll();

    // Preload every word; CPU write is held off by init_we priority
    for (int i = 0; i < DEPTH; i++) begin
      cycle(32'h0, 32'h0, 1'b1, 1'b1, 8'(i), (i == 3) ? 32'h8C220004 : $urandom());
    end

    // Fetch timing
    cycle(32'h0C, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    checkEq("fetch_busy_c1", {31'b0, busy}, 32'h1);
    cycle(32'h0C, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    checkEq("fetch_rdata", rdata, 32'h8C220004);
    checkEq("fetch_rvalid", {31'b0, rvalid}, 32'h1);

    // Store held two cycles, then load
    cycle(32'h40, 32'hDEADBEEF, 1'b1, 1'b0, 8'h0, 32'h0);
    cycle(32'h40, 32'hDEADBEEF, 1'b1, 1'b0, 8'h0, 32'h0);
    checkEq("store_wr_count", {16'b0, wr_count}, 32'd2);
    cycle(32'h40, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    cycle(32'h40, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    checkEq("load_rdata", rdata, 32'hDEADBEEF);

    // Write-first collision, then preload-over-CPU collision on index 8
    cycle(32'h20, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    cycle(32'h20, 32'h12345678, 1'b1, 1'b0, 8'h0, 32'h0);
    checkEq("collide_cpu", rdata, 32'h12345678);
    cycle(32'h20, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    cycle(32'h20, 32'hAAAA5555, 1'b1, 1'b1, 8'd8, 32'hCAFEF00D);
    checkEq("collide_init", rdata, 32'hCAFEF00D);
    checkEq("collide_wr_count", {16'b0, wr_count}, 32'd3);
    cycle(32'h20, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    cycle(32'h20, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    checkEq("init_kept", rdata, 32'hCAFEF00D);

    // Misaligned write is dropped; misaligned read wraps and aligns down
    cycle(32'h42, 32'h0BADF00D, 1'b1, 1'b0, 8'h0, 32'h0);
    checkEq("misalign_err", {31'b0, err}, 32'h1);
    cycle(32'h40, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    cycle(32'h40, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    checkEq("misalign_nowrite", rdata, 32'hDEADBEEF);
    cycle(32'h401, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    cycle(32'h401, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);

    // Random traffic confined to words 64..255
    for (int n = 0; n < 300; n++) begin
      int          r  = $urandom_range(0, 9);
      logic [31:0] a  = (32'($urandom_range(64, 255)) << 2) | (32'($urandom_range(0, 15)) << 10);
      if (r == 9) a = a | 32'h1;
      cycle(a, $urandom(), r < 4, r == 0, 8'($urandom_range(64, 255)), $urandom());
    end

    // Asynchronous reset with a read in flight
    cycle(32'h100, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    #2 reset = 1'b1;
    modelReset();
    #1 compareAll();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compareAll();
    cycle(32'h0C, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    checkEq("post_reset_norvalid", {31'b0, rvalid}, 32'h0);
    cycle(32'h0C, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    checkEq("post_reset_contents", rdata, 32'h8C220004);

    // Read counter saturation
    for (int n = 0; n < 65540; n++) begin
      cycle(32'h100, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    end
    checkEq("rd_sat", {16'b0, rd_count}, 32'h0000FFFF);
    cycle(32'h100, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    cycle(32'h100, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    checkEq("rd_sat_hold", {16'b0, rd_count}, 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
